link_arbiter: RTL and testbench
===============================

# link_arbiter

Two-master arbiter placed in front of the tree link's single master port, so the UART bridge (m0) and a second on-chip master (m1, e.g. a boot/script sequencer) share access to the linebuffer, clock/reset and debugger slaves. It grants one complete command/response transaction at a time, round-robin between requesters. All ports use the team's 3-bit MCmd / 2-bit SResp request-response handshake. Optionally, a response timeout returns an error to the master when a slave hangs.

## Interface
- TIMEOUT_CYCLES, 255, response-wait cycles before an error is returned; legal range 1..255; used only with the timeout feature.
- clk  in  1  50 MHz link clock.
- rst  in  1  asynchronous, active-high reset.
- m0_MCmd  in  3  UART master command: 000 IDLE, 001 WR, 010 RD.
- m0_MAddr / m0_MData  in  8 / 8  UART master address / write data.
- m0_SCmdAccept  out  1  command accepted.
- m0_SData  out  8  read data.
- m0_SResp  out  2  response: 00 NULL, 01 DVA, 11 ERR.
- m0_MRespAccept  in  1  master accepts response.
- m1_*  same seven signals, same widths and directions, for master 1.
- s_MCmd / s_MAddr / s_MData  out  3 / 8 / 8  toward the tree link's master port.
- s_SCmdAccept  in  1  tree link accepted command.
- s_SData / s_SResp  in  8 / 2  response from the tree link.
- s_MRespAccept  out  1  response accepted.
- grant  out  2  debug monitor: 00 none, 01 m0, 10 m1.
- arb_state  out  2  debug monitor: 00 IDLE, 01 CMD, 10 RESP, 11 ERR.

## Operation
- A master requests when its MCmd != 000. Every WR and RD produces exactly one response.
- IDLE:
  - Slave-side outputs are zero.
  - If any request is present, register grant and go to CMD.
  - If both request, grant the master not granted last. The last-grant pointer resets to m1, so m0 wins the first tie.
- CMD:
  - s_MCmd/MAddr/MData are driven combinationally from the granted master.
  - The granted master's SCmdAccept = s_SCmdAccept. The other master's SCmdAccept = 0.
  - If s_SCmdAccept=1 and s_MCmd != 000, go to RESP.
  - If the granted master's MCmd drops to 000 (protocol violation), return to IDLE. Grant clears and the pointer is not updated.
- RESP:
  - s_MCmd = 000.
  - The granted master receives s_SResp/s_SData combinationally. s_MRespAccept = the granted master's MRespAccept.
  - The non-granted master always sees SResp=00 and SData=00.
  - If s_SResp != 00 and MRespAccept=1, go to IDLE, update the last-grant pointer, and clear grant.
- The non-granted master's request is held off. Its command lines are never forwarded.
- Reset values, valid mid-transaction as well:
  - State IDLE, grant 00, arb_state 00, pointer = m1, timeout counter 0.
  - All SCmdAccept, SResp, SData and s_* outputs 0.
  - Any in-flight transaction is abandoned.

## Timing
- Request seen in IDLE at cycle N → s_MCmd valid at N+1 (one-cycle grant latency).
- Accept at N+1 → RESP at N+2. Response accepted at N+2 → IDLE at N+3.
- Minimum transaction is 3 cycles. There is one IDLE cycle between back-to-back transactions.
- Command and response paths are purely combinational through the mux; there is no data register stage.
- Both masters requesting continuously → strictly alternating grants.

## Configuration
- LINK_ARB_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to RESP and increments each RESP cycle with s_SResp=00.
  - When TIMEOUT_CYCLES consecutive NULL cycles have elapsed, go to ERR.
  - ERR: granted master sees SResp=11, SData=00 until MRespAccept=1, then IDLE with pointer update.
  - In IDLE and ERR, s_MRespAccept=1 to drain late slave responses. A late response is never forwarded to a master.
- LINK_ARB_TIMEOUT_EN undefined:
  - No counter. RESP waits indefinitely and ERR (11) is unreachable.
  - s_MRespAccept=0 outside RESP.

## Test plan
- m0 RD addr 8'h10, slave accepts immediately, returns DVA with data 8'hA5 one cycle later → m0_SData=A5 and m0_SResp=01 at cycle N+2; IDLE at N+3; m1 outputs stay 0.
- m0 and m1 both WR from reset → m0 granted first, then m1, then m0 again if m0 re-requests; grant sequence 01,00,10,00,01.
- Slave holds s_SCmdAccept=0 for 5 cycles during an m1 WR → s_MCmd held at 001 with m1's addr/data; m1_SCmdAccept=0 until accept; m0 blocked throughout.
- rst asserted while in RESP → all outputs 0 asynchronously; after release, next request granted from IDLE with m0 tie priority.
- With LINK_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, slave never responds → ERR after 4 NULL cycles; m0_SResp=11, SData=00; a late slave DVA in IDLE is drained with s_MRespAccept=1 and not forwarded.
- Without the macro, same stimulus → arb_state stays 10 for 300 cycles; m0_SResp=00.

Source files
------------

// File: rtl/link_arbiter.sv
// link_arbiter: two-master round-robin arbiter in front of the tree link master port.
// Grants one complete command/response transaction at a time to m0 or m1.
// Optional response timeout enabled by defining LINK_ARB_TIMEOUT_EN.
module link_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    // master 0 (UART bridge)
    input  logic [2:0] m0_MCmd,
    input  logic [7:0] m0_MAddr,
    input  logic [7:0] m0_MData,
    output logic       m0_SCmdAccept,
    output logic [7:0] m0_SData,
    output logic [1:0] m0_SResp,
    input  logic       m0_MRespAccept,
    // master 1 (on-chip sequencer)
    input  logic [2:0] m1_MCmd,
    input  logic [7:0] m1_MAddr,
    input  logic [7:0] m1_MData,
    output logic       m1_SCmdAccept,
    output logic [7:0] m1_SData,
    output logic [1:0] m1_SResp,
    input  logic       m1_MRespAccept,
    // toward the tree link
    output logic [2:0] s_MCmd,
    output logic [7:0] s_MAddr,
    output logic [7:0] s_MData,
    input  logic       s_SCmdAccept,
    input  logic [7:0] s_SData,
    input  logic [1:0] s_SResp,
    output logic       s_MRespAccept,
    // debug monitors
    output logic [1:0] grant,
    output logic [1:0] arb_state
);

    localparam int unsigned CMD_W  = 3;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned RESP_W = 2;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_CMD  = 2'b01;
    localparam logic [1:0] ST_RESP = 2'b10;
    localparam logic [1:0] ST_ERR  = 2'b11;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    localparam logic [CMD_W-1:0]  CMD_IDLE  = 3'b000;
    localparam logic [RESP_W-1:0] RESP_NULL = 2'b00;

    if ((TIMEOUT_CYCLES == 0) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
        $error("link_arbiter: TIMEOUT_CYCLES must be in 1..255");
    end

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [1:0]        r_grant;
    logic [1:0]        w_grant_nxt;
    logic              r_last_m1;
    logic              w_last_m1_nxt;

    logic              w_m0_req;
    logic              w_m1_req;
    logic [CMD_W-1:0]  w_g_cmd;
    logic [DATA_W-1:0] w_g_addr;
    logic [DATA_W-1:0] w_g_data;
    logic              w_g_racc;
    logic              w_cacc;
    logic [RESP_W-1:0] w_resp;
    logic [DATA_W-1:0] w_rdata;

`ifdef LINK_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
`endif

    assign w_m0_req  = (m0_MCmd != CMD_IDLE);
    assign w_m1_req  = (m1_MCmd != CMD_IDLE);
    assign grant     = r_grant;
    assign arb_state = r_state;

    // Select the granted master's request lines
    always_comb begin
        w_g_cmd  = CMD_IDLE;
        w_g_addr = '0;
        w_g_data = '0;
        w_g_racc = 1'b0;
        case (r_grant)
            GNT_M0: begin
                w_g_cmd  = m0_MCmd;
                w_g_addr = m0_MAddr;
                w_g_data = m0_MData;
                w_g_racc = m0_MRespAccept;
            end
            GNT_M1: begin
                w_g_cmd  = m1_MCmd;
                w_g_addr = m1_MAddr;
                w_g_data = m1_MData;
                w_g_racc = m1_MRespAccept;
            end
            default: ;
        endcase
    end

    // Next state, grant and round-robin pointer
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_last_m1_nxt = r_last_m1;
`ifdef LINK_ARB_TIMEOUT_EN
        w_cnt_nxt     = r_cnt;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_m0_req && w_m1_req) begin
                    w_grant_nxt = r_last_m1 ? GNT_M0 : GNT_M1;
                    w_state_nxt = ST_CMD;
                end else if (w_m0_req) begin
                    w_grant_nxt = GNT_M0;
                    w_state_nxt = ST_CMD;
                end else if (w_m1_req) begin
                    w_grant_nxt = GNT_M1;
                    w_state_nxt = ST_CMD;
                end
            end
            ST_CMD: begin
                // A withdrawn command abandons the grant without moving the pointer
                if (w_g_cmd == CMD_IDLE) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = GNT_NONE;
                end else if (s_SCmdAccept) begin
                    w_state_nxt = ST_RESP;
`ifdef LINK_ARB_TIMEOUT_EN
                    w_cnt_nxt   = '0;
`endif
                end
            end
            ST_RESP: begin
                if (s_SResp != RESP_NULL) begin
                    if (w_g_racc) begin
                        w_state_nxt   = ST_IDLE;
                        w_grant_nxt   = GNT_NONE;
                        w_last_m1_nxt = (r_grant == GNT_M1);
                    end
`ifdef LINK_ARB_TIMEOUT_EN
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (r_cnt == TO_LAST) begin
                        w_state_nxt = ST_ERR;
                    end
`endif
                end
            end
`ifdef LINK_ARB_TIMEOUT_EN
            ST_ERR: begin
                if (w_g_racc) begin
                    w_state_nxt   = ST_IDLE;
                    w_grant_nxt   = GNT_NONE;
                    w_last_m1_nxt = (r_grant == GNT_M1);
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = GNT_NONE;
            end
        endcase
    end

    // Combinational command/response mux toward slave and granted master
    always_comb begin
        s_MCmd        = CMD_IDLE;
        s_MAddr       = '0;
        s_MData       = '0;
        s_MRespAccept = 1'b0;
        m0_SCmdAccept = 1'b0;
        m0_SResp      = RESP_NULL;
        m0_SData      = '0;
        m1_SCmdAccept = 1'b0;
        m1_SResp      = RESP_NULL;
        m1_SData      = '0;
        w_cacc        = 1'b0;
        w_resp        = RESP_NULL;
        w_rdata       = '0;
        case (r_state)
            ST_CMD: begin
                s_MCmd  = w_g_cmd;
                s_MAddr = w_g_addr;
                s_MData = w_g_data;
                w_cacc  = s_SCmdAccept;
            end
            ST_RESP: begin
                w_resp        = s_SResp;
                w_rdata       = s_SData;
                s_MRespAccept = w_g_racc;
            end
`ifdef LINK_ARB_TIMEOUT_EN
            ST_ERR: begin
                // Report error and drain any late slave response
                w_resp        = 2'b11;
                s_MRespAccept = 1'b1;
            end
            ST_IDLE: begin
                s_MRespAccept = ~rst;
            end
`endif
            default: ;
        endcase
        if (r_grant == GNT_M0) begin
            m0_SCmdAccept = w_cacc;
            m0_SResp      = w_resp;
            m0_SData      = w_rdata;
        end else if (r_grant == GNT_M1) begin
            m1_SCmdAccept = w_cacc;
            m1_SResp      = w_resp;
            m1_SData      = w_rdata;
        end
    end

    // State, grant and pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_grant   <= GNT_NONE;
            r_last_m1 <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_last_m1 <= w_last_m1_nxt;
        end
    end

`ifdef LINK_ARB_TIMEOUT_EN
    // Consecutive NULL-response cycle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_link_arbiter.sv
// tb_link_arbiter: directed stimulus with per-master scoreboards for link_arbiter.
`timescale 1ns/1ps
module tb_link_arbiter;

    localparam int unsigned TO = 4;

    typedef struct packed {
        logic [2:0] cmd;
        logic [7:0] addr;
        logic [7:0] data;
    } cmd_t;

    typedef struct packed {
        logic [1:0] resp;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] mcmd  [2];
    logic [7:0] maddr [2];
    logic [7:0] mdata [2];
    logic       mracc [2];

    logic       m0_SCmdAccept, m1_SCmdAccept;
    logic [7:0] m0_SData, m1_SData;
    logic [1:0] m0_SResp, m1_SResp;
    logic [2:0] s_MCmd;
    logic [7:0] s_MAddr, s_MData, s_SData;
    logic       s_SCmdAccept, s_MRespAccept;
    logic [1:0] s_SResp;
    logic [1:0] grant, arb_state;

    int   n_cmp = 0;
    int   n_bad = 0;
    cmd_t cq0[$], cq1[$];
    exp_t eq0[$], eq1[$];

    // slave model state
    int         acc_wait = 0;
    int         acc_cnt;
    bit         no_resp = 0;
    bit         late_req = 0;
    logic       pend;
    logic [7:0] pdata;
    logic [7:0] mem [256];

    // grant-sequence log
    logic [1:0] glog[$];
    logic [1:0] gprev;
    bit         log_en = 0;

    link_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_MCmd(mcmd[0]), .m0_MAddr(maddr[0]), .m0_MData(mdata[0]),
        .m0_SCmdAccept(m0_SCmdAccept), .m0_SData(m0_SData), .m0_SResp(m0_SResp),
        .m0_MRespAccept(mracc[0]),
        .m1_MCmd(mcmd[1]), .m1_MAddr(maddr[1]), .m1_MData(mdata[1]),
        .m1_SCmdAccept(m1_SCmdAccept), .m1_SData(m1_SData), .m1_SResp(m1_SResp),
        .m1_MRespAccept(mracc[1]),
        .s_MCmd(s_MCmd), .s_MAddr(s_MAddr), .s_MData(s_MData),
        .s_SCmdAccept(s_SCmdAccept), .s_SData(s_SData), .s_SResp(s_SResp),
        .s_MRespAccept(s_MRespAccept),
        .grant(grant), .arb_state(arb_state)
    );

    always #10 clk = ~clk;

    // Slave: accepts after acc_wait stalled cycles, answers DVA one cycle after accept
    assign s_SCmdAccept = (s_MCmd != 3'b000) && (acc_cnt >= acc_wait);
    assign s_SResp      = pend ? 2'b01 : 2'b00;
    assign s_SData      = pend ? pdata : 8'h00;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend    <= 1'b0;
            pdata   <= 8'h00;
            acc_cnt <= 0;
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[8'h10] <= 8'hA5;
        end else begin
            if (pend && s_MRespAccept) pend <= 1'b0;
            if (s_MCmd != 3'b000 && s_SCmdAccept) begin
                acc_cnt <= 0;
                if (s_MCmd == 3'b001) mem[s_MAddr] <= s_MData;
                if (!no_resp) begin
                    pend  <= 1'b1;
                    pdata <= (s_MCmd == 3'b010) ? mem[s_MAddr] : 8'h00;
                end
            end else if (s_MCmd != 3'b000) begin
                acc_cnt <= acc_cnt + 1;
            end
            if (late_req) begin
                pend  <= 1'b1;
                pdata <= 8'h77;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic issue(input int m, input logic [2:0] cmd, input logic [7:0] addr,
                         input logic [7:0] data, input logic [1:0] eresp,
                         input logic [7:0] edata, input bit expect_rsp);
        cmd_t c;
        exp_t e;
        c.cmd = cmd; c.addr = addr; c.data = data;
        e.resp = eresp; e.data = edata;
        if (m == 0) begin
            cq0.push_back(c);
            if (expect_rsp) eq0.push_back(e);
        end else begin
            cq1.push_back(c);
            if (expect_rsp) eq1.push_back(e);
        end
    endtask

    // Master driver: one outstanding transaction, accepts responses immediately
    task automatic master_run(input int m);
        bit   acc, rsp, waiting;
        int   qn;
        cmd_t c;
        waiting = 0;
        forever begin
            @(negedge clk);
            if (m == 0) begin
                acc = m0_SCmdAccept && (mcmd[0] != 3'b000);
                rsp = (m0_SResp != 2'b00) && mracc[0];
            end else begin
                acc = m1_SCmdAccept && (mcmd[1] != 3'b000);
                rsp = (m1_SResp != 2'b00) && mracc[1];
            end
            @(posedge clk);
            #1;
            if (rst) begin
                mcmd[m] = 3'b000; maddr[m] = 8'h00; mdata[m] = 8'h00;
                waiting = 0;
            end else begin
                if (acc) begin
                    mcmd[m] = 3'b000;
                    waiting = 1;
                end
                if (rsp) waiting = 0;
                qn = (m == 0) ? cq0.size() : cq1.size();
                if (!waiting && mcmd[m] == 3'b000 && qn != 0) begin
                    if (m == 0) c = cq0.pop_front();
                    else        c = cq1.pop_front();
                    mcmd[m] = c.cmd; maddr[m] = c.addr; mdata[m] = c.data;
                end
            end
        end
    endtask

    // Scoreboard monitor: pop and compare on every response handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (m0_SResp != 2'b00 && mracc[0]) begin
                    if (eq0.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL m0_unexpected_resp: got resp %b data %h, expected none", m0_SResp, m0_SData);
                    end else begin
                        e = eq0.pop_front();
                        chk("m0_sb_resp", 32'(m0_SResp), 32'(e.resp));
                        chk("m0_sb_data", 32'(m0_SData), 32'(e.data));
                    end
                end
                if (m1_SResp != 2'b00 && mracc[1]) begin
                    if (eq1.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL m1_unexpected_resp: got resp %b data %h, expected none", m1_SResp, m1_SData);
                    end else begin
                        e = eq1.pop_front();
                        chk("m1_sb_resp", 32'(m1_SResp), 32'(e.resp));
                        chk("m1_sb_data", 32'(m1_SData), 32'(e.data));
                    end
                end
            end
        end
    end

    // Grant change logger
    initial begin
        forever begin
            @(negedge clk);
            if (log_en && grant != gprev) begin
                glog.push_back(grant);
                gprev = grant;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((cq0.size() + cq1.size() + eq0.size() + eq1.size() != 0 || arb_state != 2'b00) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_drain: transactions still pending, expected all done", name);
        end
    endtask

    task automatic wait_cmd(input string name);
        int k;
        k = 0;
        while (s_MCmd == 3'b000 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_wait_cmd: s_MCmd stayed 0, expected a command", name);
        end
    endtask

    task automatic wait_state(input logic [1:0] st, input string name);
        int k;
        k = 0;
        while (arb_state != st && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_wait_state: arb_state %b, expected %b", name, arb_state, st);
        end
    endtask

    initial begin
        logic [1:0] gexp [6];
        gexp[0] = 2'b01; gexp[1] = 2'b00; gexp[2] = 2'b10;
        gexp[3] = 2'b00; gexp[4] = 2'b01; gexp[5] = 2'b00;
        for (int i = 0; i < 2; i++) begin
            mcmd[i] = 3'b000; maddr[i] = 8'h00; mdata[i] = 8'h00; mracc[i] = 1'b1;
        end
        fork
            master_run(0);
            master_run(1);
        join_none

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(arb_state), 32'h0);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_s_cmd", 32'({s_MCmd, s_MAddr, s_MData}), 32'h0);
        chk("rst_s_racc", 32'(s_MRespAccept), 32'h0);
        chk("rst_m0_out", 32'({m0_SCmdAccept, m0_SResp, m0_SData}), 32'h0);
        chk("rst_m1_out", 32'({m1_SCmdAccept, m1_SResp, m1_SData}), 32'h0);
        @(posedge clk);
        #2 rst = 1'b0;

        // both masters write from reset: m0, m1, m0 alternation
        @(negedge clk);
        glog.delete();
        gprev  = grant;
        log_en = 1;
        issue(0, 3'b001, 8'h20, 8'h11, 2'b01, 8'h00, 1);
        issue(1, 3'b001, 8'h30, 8'h33, 2'b01, 8'h00, 1);
        issue(0, 3'b001, 8'h21, 8'h22, 2'b01, 8'h00, 1);
        drain("t2");
        log_en = 0;
        chk("t2_glog_len", 32'(glog.size()), 32'd6);
        for (int i = 0; i < 6; i++) chk("t2_grant_seq", 32'(glog[i]), 32'(gexp[i]));

        // m0 read with immediate accept and one-cycle response
        issue(0, 3'b010, 8'h10, 8'h00, 2'b01, 8'hA5, 1);
        wait_cmd("t1");
        chk("t1_s_cmd", 32'(s_MCmd), 32'h2);
        chk("t1_s_addr", 32'(s_MAddr), 32'h10);
        chk("t1_m0_acc", 32'(m0_SCmdAccept), 32'h1);
        chk("t1_m1_acc", 32'(m1_SCmdAccept), 32'h0);
        chk("t1_state_cmd", 32'(arb_state), 32'h1);
        @(negedge clk);
        chk("t1_state_resp", 32'(arb_state), 32'h2);
        chk("t1_m0_resp", 32'(m0_SResp), 32'h1);
        chk("t1_m0_data", 32'(m0_SData), 32'hA5);
        chk("t1_m1_quiet", 32'({m1_SResp, m1_SData}), 32'h0);
        chk("t1_s_racc", 32'(s_MRespAccept), 32'h1);
        @(negedge clk);
        chk("t1_state_idle", 32'(arb_state), 32'h0);
        chk("t1_grant_idle", 32'(grant), 32'h0);
        drain("t1");

        // slave stalls m1 write for 5 cycles; m0 blocked, then reads back
        acc_wait = 5;
        issue(1, 3'b001, 8'h33, 8'h5C, 2'b01, 8'h00, 1);
        issue(0, 3'b010, 8'h33, 8'h00, 2'b01, 8'h5C, 1);
        wait_cmd("t3");
        for (int i = 0; i < 5; i++) begin
            chk("t3_s_cmd", 32'(s_MCmd), 32'h1);
            chk("t3_s_addr", 32'(s_MAddr), 32'h33);
            chk("t3_s_data", 32'(s_MData), 32'h5C);
            chk("t3_m1_acc", 32'(m1_SCmdAccept), 32'h0);
            chk("t3_m0_acc", 32'(m0_SCmdAccept), 32'h0);
            chk("t3_grant", 32'(grant), 32'h2);
            @(negedge clk);
        end
        chk("t3_m1_accept", 32'(m1_SCmdAccept), 32'h1);
        acc_wait = 0;
        drain("t3");

        // asynchronous reset during RESP, then tie goes to m0
        no_resp = 1;
        issue(1, 3'b010, 8'h44, 8'h00, 2'b00, 8'h00, 0);
        wait_state(2'b10, "t4");
        #2 rst = 1'b1;
        #1;
        chk("t4_state", 32'(arb_state), 32'h0);
        chk("t4_grant", 32'(grant), 32'h0);
        chk("t4_s_cmd", 32'({s_MCmd, s_MAddr, s_MData}), 32'h0);
        chk("t4_s_racc", 32'(s_MRespAccept), 32'h0);
        chk("t4_m1_out", 32'({m1_SCmdAccept, m1_SResp, m1_SData}), 32'h0);
        chk("t4_m0_out", 32'({m0_SCmdAccept, m0_SResp, m0_SData}), 32'h0);
        no_resp = 0;
        issue(0, 3'b001, 8'h50, 8'h01, 2'b01, 8'h00, 1);
        issue(1, 3'b001, 8'h51, 8'h02, 2'b01, 8'h00, 1);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        wait_cmd("t4");
        chk("t4_tie_grant", 32'(grant), 32'h1);
        drain("t4");

`ifdef LINK_ARB_TIMEOUT_EN
        // slave never responds: error after TO NULL cycles, late DVA drained
        no_resp = 1;
        issue(0, 3'b010, 8'h60, 8'h00, 2'b11, 8'h00, 1);
        wait_state(2'b10, "t5");
        repeat (3) @(negedge clk);
        chk("t5_still_resp", 32'(arb_state), 32'h2);
        @(negedge clk);
        chk("t5_err_state", 32'(arb_state), 32'h3);
        chk("t5_err_resp", 32'(m0_SResp), 32'h3);
        chk("t5_err_data", 32'(m0_SData), 32'h0);
        chk("t5_m1_quiet", 32'(m1_SResp), 32'h0);
        @(negedge clk);
        chk("t5_idle", 32'(arb_state), 32'h0);
        @(posedge clk);
        #1 late_req = 1;
        @(posedge clk);
        #1 late_req = 0;
        @(negedge clk);
        chk("t5_drain_racc", 32'(s_MRespAccept), 32'h1);
        chk("t5_late_m0", 32'(m0_SResp), 32'h0);
        chk("t5_late_m1", 32'(m1_SResp), 32'h0);
        @(negedge clk);
        chk("t5_drained", 32'(s_SResp), 32'h0);
        no_resp = 0;
`else
        // slave never responds: arbiter waits in RESP indefinitely
        no_resp = 1;
        issue(0, 3'b010, 8'h60, 8'h00, 2'b00, 8'h00, 0);
        wait_state(2'b10, "t5");
        repeat (300) @(negedge clk);
        chk("t5_hold_resp", 32'(arb_state), 32'h2);
        chk("t5_m0_null", 32'(m0_SResp), 32'h0);
        chk("t5_grant", 32'(grant), 32'h1);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_state", 32'(arb_state), 32'h0);
        no_resp = 0;
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
`endif

        chk("end_sb0_empty", 32'(eq0.size()), 32'h0);
        chk("end_sb1_empty", 32'(eq1.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
